// File: rtl/trackball_pkg.sv
// Shared constants and helpers for the trackball quadrature emulator.
// Phase encoding is {a, b}; forward order is PH0 -> PH1 -> PH2 -> PH3 -> PH0.
package trackball_pkg;

    localparam logic [1:0] PH0 = 2'b00;
    localparam logic [1:0] PH1 = 2'b10;
    localparam logic [1:0] PH2 = 2'b11;
    localparam logic [1:0] PH3 = 2'b01;

    function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic fwd);
        logic [1:0] r_nxt;
        r_nxt = PH0;
        case (ph)
            PH0:     r_nxt = fwd ? PH1 : PH3;
            PH1:     r_nxt = fwd ? PH2 : PH0;
            PH2:     r_nxt = fwd ? PH3 : PH1;
            default: r_nxt = fwd ? PH0 : PH2;
        endcase
        return r_nxt;
    endfunction

    // Clamp to +/-(2^(acc_w-1)-1) so the most negative code is never produced.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] x,
                                                   input logic signed [31:0] y,
                                                   input int unsigned      acc_w);
        logic signed [31:0] lim;
        logic signed [31:0] sum;
        lim = (32'sd1 <<< (acc_w - 1)) - 32'sd1;
        sum = x + y;
        if (sum > lim) begin
            sum = lim;
        end else if (sum < -lim) begin
            sum = -lim;
        end
        return sum;
    endfunction

    function automatic logic signed [1:0] dir2(input logic pos, input logic neg);
        logic signed [1:0] d;
        d = 2'sb00;
        case ({pos, neg})
            2'b10:   d = 2'sb01;
            2'b01:   d = 2'sb11;
            default: d = 2'sb00;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/quad_axis_gen.sv
// One quadrature axis: a saturating signed backlog of motion drained one phase
// step per shared tick.
module quad_axis_gen
    import trackball_pkg::*;
#(
    parameter int unsigned ACC_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic signed [8:0] mdelta,
    input  logic signed [1:0] jdelta,
    input  logic              tick,
    output logic              a,
    output logic              b
);

    localparam logic signed [ACC_W+1:0] ONE = (ACC_W + 2)'(1);

    logic signed [ACC_W-1:0] r_pending;
    logic [1:0]              r_phase;
    logic                    w_fwd;
    logic                    w_bwd;
    logic signed [ACC_W+1:0] w_delta;
    logic signed [ACC_W-1:0] w_pending_d;

    always_comb begin
        w_fwd   = tick && !r_pending[ACC_W-1] && (r_pending != '0);
        w_bwd   = tick && r_pending[ACC_W-1];
        w_delta = (ACC_W + 2)'(mdelta) + (ACC_W + 2)'(jdelta);
        // The step direction comes from the pre-update backlog.
        if (w_fwd) begin
            w_delta = w_delta - ONE;
        end else if (w_bwd) begin
            w_delta = w_delta + ONE;
        end
        w_pending_d = ACC_W'(sat_add(32'(r_pending), 32'(w_delta), ACC_W));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            r_phase   <= PH0;
        end else begin
            r_pending <= w_pending_d;
            if (w_fwd || w_bwd) begin
                r_phase <= next_phase(r_phase, w_fwd);
            end
        end
    end

    assign a = r_phase[1];
    assign b = r_phase[0];

endmodule

// File: rtl/trackball_quad_gen.sv
// Turns host mouse deltas and joystick directions into rate-limited trackball
// quadrature pairs for the LETA interface.
module trackball_quad_gen
    import trackball_pkg::*;
#(
    parameter int unsigned STEP_DIV = 64,
    parameter int unsigned JOY_DIV  = 4096,
    parameter int unsigned ACC_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mouse_strobe,
    input  logic signed [8:0] mouse_dx,
    input  logic signed [8:0] mouse_dy,
    input  logic              joy_right,
    input  logic              joy_left,
    input  logic              joy_up,
    input  logic              joy_down,
    output logic              h_a,
    output logic              h_b,
    output logic              v_a,
    output logic              v_b
);

    localparam int unsigned SW = $clog2(STEP_DIV);
    localparam int unsigned JW = $clog2(JOY_DIV);
    localparam logic [SW-1:0] STEP_LOAD = SW'(STEP_DIV - 1);
    localparam logic [JW-1:0] JOY_LOAD  = JW'(JOY_DIV - 1);

    logic [SW-1:0]     r_step_cnt;
    logic [JW-1:0]     r_joy_cnt;
    logic              w_step_tick;
    logic              w_joy_tick;
    logic signed [8:0] w_mdx;
    logic signed [8:0] w_mdy;
    logic signed [1:0] w_jdx;
    logic signed [1:0] w_jdy;

    always_comb begin
        w_step_tick = (r_step_cnt == '0);
        w_joy_tick  = (r_joy_cnt == '0);
        w_mdx       = mouse_strobe ? mouse_dx : 9'sd0;
        w_mdy       = mouse_strobe ? mouse_dy : 9'sd0;
        w_jdx       = w_joy_tick ? dir2(joy_right, joy_left) : 2'sb00;
        w_jdy       = w_joy_tick ? dir2(joy_up, joy_down) : 2'sb00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_step_cnt <= STEP_LOAD;
            r_joy_cnt  <= JOY_LOAD;
        end else begin
            r_step_cnt <= w_step_tick ? STEP_LOAD : r_step_cnt - SW'(1);
            r_joy_cnt  <= w_joy_tick ? JOY_LOAD : r_joy_cnt - JW'(1);
        end
    end

    quad_axis_gen #(
        .ACC_W (ACC_W)
    ) u_axis_h (
        .clk    (clk),
        .reset  (reset),
        .mdelta (w_mdx),
        .jdelta (w_jdx),
        .tick   (w_step_tick),
        .a      (h_a),
        .b      (h_b)
    );

    quad_axis_gen #(
        .ACC_W (ACC_W)
    ) u_axis_v (
        .clk    (clk),
        .reset  (reset),
        .mdelta (w_mdy),
        .jdelta (w_jdy),
        .tick   (w_step_tick),
        .a      (v_a),
        .b      (v_b)
    );

endmodule

// File: tb/tb_trackball_quad_gen.sv
// Scoreboard bench: stimulus queues expected phases, a monitor pops them on each
// observed output edge and decodes net motion per axis.
module tb_trackball_quad_gen;

    localparam int STEP_DIV = 4;
    localparam int JOY_DIV  = 16;
    localparam int ACC_W    = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              mouse_strobe = 1'b0;
    logic signed [8:0] mouse_dx = '0;
    logic signed [8:0] mouse_dy = '0;
    logic              joy_right = 1'b0;
    logic              joy_left = 1'b0;
    logic              joy_up = 1'b0;
    logic              joy_down = 1'b0;
    logic              h_a, h_b, v_a, v_b;

    trackball_quad_gen #(
        .STEP_DIV (STEP_DIV),
        .JOY_DIV  (JOY_DIV),
        .ACC_W    (ACC_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mouse_strobe (mouse_strobe),
        .mouse_dx     (mouse_dx),
        .mouse_dy     (mouse_dy),
        .joy_right    (joy_right),
        .joy_left     (joy_left),
        .joy_up       (joy_up),
        .joy_down     (joy_down),
        .h_a          (h_a),
        .h_b          (h_b),
        .v_a          (v_a),
        .v_b          (v_b)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [1:0] exp_q_h[$];
    logic [1:0] exp_q_v[$];
    logic [1:0] seq[4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    int cyc = 0;
    int mcnt = STEP_DIV - 1;
    int idx_h = 0, idx_v = 0;
    int n_h = 0, n_v = 0, last_h = 0, last_v = 0, first_h = 0, first_v = 0;
    int dec_h = 0, dec_v = 0;
    bit chk_spacing = 1'b1;
    logic [1:0] prev_h = 2'b00, prev_v = 2'b00;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic int pos_of(input logic [1:0] p);
        for (int i = 0; i < 4; i++) if (seq[i] == p) return i;
        return 0;
    endfunction

    task automatic axis_edge(input int axis, input logic [1:0] cur);
        logic [1:0] prv;
        logic [1:0] e;
        int d;
        prv = (axis == 0) ? prev_h : prev_v;
        d = (pos_of(cur) - pos_of(prv) + 4) % 4;
        chk(axis == 0 ? "h_single_bit_edge" : "v_single_bit_edge", int'(d == 1 || d == 3), 1);
        d = (d == 1) ? 1 : ((d == 3) ? -1 : 0);
        if ((axis == 0 ? exp_q_h.size() : exp_q_v.size()) == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_edge axis %0d at cycle %0d: got %b, required no edge",
                     axis, cyc, cur);
        end else begin
            e = (axis == 0) ? exp_q_h.pop_front() : exp_q_v.pop_front();
            chk(axis == 0 ? "h_phase" : "v_phase", int'(cur), int'(e));
        end
        if (axis == 0) begin
            if (n_h > 0 && chk_spacing) chk("h_edge_spacing", cyc - last_h, STEP_DIV);
            if (n_h == 0) first_h = cyc;
            n_h++; last_h = cyc; dec_h += d; prev_h = cur;
        end else begin
            if (n_v > 0 && chk_spacing) chk("v_edge_spacing", cyc - last_v, STEP_DIV);
            if (n_v == 0) first_v = cyc;
            n_v++; last_v = cyc; dec_v += d; prev_v = cur;
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            mcnt   = STEP_DIV - 1;
            prev_h = {h_a, h_b};
            prev_v = {v_a, v_b};
        end else begin
            mcnt = (mcnt == 0) ? STEP_DIV - 1 : mcnt - 1;
            if ({h_a, h_b} !== prev_h) axis_edge(0, {h_a, h_b});
            if ({v_a, v_b} !== prev_v) axis_edge(1, {v_a, v_b});
        end
    end

    task automatic clear_stats();
        n_h = 0; n_v = 0; dec_h = 0; dec_v = 0; first_h = 0; first_v = 0;
    endtask

    task automatic push_steps(input int axis, input int n, input bit fwd);
        for (int i = 0; i < n; i++) begin
            if (axis == 0) begin
                idx_h = fwd ? (idx_h + 1) % 4 : (idx_h + 3) % 4;
                exp_q_h.push_back(seq[idx_h]);
            end else begin
                idx_v = fwd ? (idx_v + 1) % 4 : (idx_v + 3) % 4;
                exp_q_v.push_back(seq[idx_v]);
            end
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idx_h = 0;
        idx_v = 0;
        chk(name, int'({h_a, h_b, v_a, v_b}), 0);
    endtask

    // Leaves the bench at a negedge where the next rising edge is a step tick.
    task automatic wait_tick_next();
        for (int g = 0; g < 2 * STEP_DIV && mcnt != 0; g++) @(negedge clk);
        chk("tick_alignment", int'(mcnt == 0), 1);
    endtask

    task automatic strobe(input logic signed [8:0] dx, input logic signed [8:0] dy);
        mouse_strobe = 1'b1;
        mouse_dx = dx;
        mouse_dy = dy;
        @(negedge clk);
        mouse_strobe = 1'b0;
        mouse_dx = '0;
        mouse_dy = '0;
    endtask

    task automatic settle(input int n, input string name);
        repeat (n) @(negedge clk);
        chk({name, "_h_drained"}, exp_q_h.size(), 0);
        chk({name, "_v_drained"}, exp_q_v.size(), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_outputs", int'({h_a, h_b, v_a, v_b}), 0);

        // Idle: no edges at all.
        clear_stats();
        settle(200, "idle");
        chk("idle_outputs", int'({h_a, h_b, v_a, v_b}), 0);
        chk("idle_edges", n_h + n_v, 0);

        // dx=+3: 10, 11, 01 then hold.
        clear_stats();
        chk_spacing = 1'b1;
        exp_q_h.push_back(2'b10);
        exp_q_h.push_back(2'b11);
        exp_q_h.push_back(2'b01);
        idx_h = 3;
        strobe(9'sd3, 9'sd0);
        settle(40, "dx3");
        chk("dx3_decode_h", dec_h, 3);
        chk("dx3_decode_v", dec_v, 0);
        chk("dx3_hold", int'({h_a, h_b}), 1);

        // dx=-2, dy=+1 from phase 00.
        do_reset("reset2_outputs");
        clear_stats();
        exp_q_h.push_back(2'b01);
        exp_q_h.push_back(2'b11);
        exp_q_v.push_back(2'b10);
        idx_h = 2;
        idx_v = 1;
        strobe(9'h1FE, 9'sd1);
        settle(40, "mixed");
        chk("mixed_decode_h", dec_h, -2);
        chk("mixed_decode_v", dec_v, 1);
        chk("mixed_same_cycle", first_h, first_v);

        // Positive saturation: 3 x +255 aligned so no step lands during the burst.
        clear_stats();
        wait_tick_next();
        push_steps(0, 511, 1'b1);
        strobe(9'sd255, 9'sd0);
        strobe(9'sd255, 9'sd0);
        strobe(9'sd255, 9'sd0);
        settle(511 * STEP_DIV + 40, "sat_pos");
        chk("sat_pos_decode", dec_h, 511);

        // Negative saturation: 3 x -256.
        clear_stats();
        wait_tick_next();
        push_steps(0, 511, 1'b0);
        strobe(9'h100, 9'sd0);
        strobe(9'h100, 9'sd0);
        strobe(9'h100, 9'sd0);
        settle(511 * STEP_DIV + 40, "sat_neg");
        chk("sat_neg_decode", dec_h, -511);

        // pending=1, then +1 on a tick cycle: one edge now, one more later.
        clear_stats();
        wait_tick_next();
        @(negedge clk);
        strobe(9'sd1, 9'sd0);
        wait_tick_next();
        push_steps(0, 2, 1'b1);
        strobe(9'sd1, 9'sd0);
        settle(40, "tick_strobe");
        chk("tick_strobe_decode", dec_h, 2);

        // Opposing joystick directions cancel.
        clear_stats();
        joy_right = 1'b1;
        joy_left  = 1'b1;
        repeat (160) @(negedge clk);
        joy_right = 1'b0;
        joy_left  = 1'b0;
        settle(20, "joy_cancel");
        chk("joy_cancel_edges", n_h, 0);

        // joy_up for 64 cycles spans exactly 4 joystick ticks.
        clear_stats();
        chk_spacing = 1'b0;
        push_steps(1, 4, 1'b1);
        joy_up = 1'b1;
        repeat (64) @(negedge clk);
        joy_up = 1'b0;
        settle(40, "joy_up");
        chk("joy_up_decode", dec_v, 4);
        chk_spacing = 1'b1;

        // Reset with a backlog of 50 discards it.
        clear_stats();
        wait_tick_next();
        push_steps(0, 2, 1'b1);
        strobe(9'sd52, 9'sd0);
        wait_tick_next();
        @(negedge clk);
        wait_tick_next();
        @(negedge clk);
        chk("pre_reset_phase", int'({h_a, h_b}), 3);
        do_reset("midstream_reset_outputs");
        clear_stats();
        settle(100, "post_reset");
        chk("post_reset_outputs", int'({h_a, h_b, v_a, v_b}), 0);
        chk("post_reset_edges", n_h + n_v, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
